picorv32_avl_bridge: RTL
========================

PICORV32_AVL_BRIDGE -- requirements
Module: picorv32_avl_bridge

Interface
REQ-001 The block SHALL have parameter BASE_HI, default 9'h000, meaning the mem_addr[31:23] value that selects this 8 MB DDR3 window.
REQ-002 The block SHALL have parameter RD_TIMEOUT, default 1023, meaning the maximum number of cycles spent in RD_WAIT before a timeout.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, exactly as follows:
- clk_clk  in  1  sole clock; all logic is rising-edge.
- reset_reset  in  1  asynchronous assert, active-high.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
- mem_valid  in  1  CPU request valid, held until mem_ready.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte strobes; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- avl_address  out  21  Avalon word address = mem_addr[22:2].
- avl_read / avl_write  out  1 each  Avalon commands.
- avl_writedata  out  32  Avalon write data.
- avl_byteenable  out  4  Avalon byte enables.
- avl_burstcount  out  3  constant 3'd1.
- avl_beginbursttransfer  out  1  first command cycle marker.
- avl_waitrequest_n  in  1  slave ready; 1 = command accepted this cycle.
- avl_readdatavalid  in  1  read data strobe.
- avl_readdata  in  32  read data.
- local_init_done  in  1  EMIF calibration complete.
- local_cal_fail  in  1  EMIF calibration failed.
- err_flag  out  1  sticky error indicator.
- busy  out  1  high in every state except IDLE and ERROR.

Function
REQ-005 The state machine SHALL have states IDLE, WR_CMD, RD_CMD, RD_WAIT, RESP and ERROR.
REQ-006 A request is selected when mem_valid=1, mem_addr[31:23]==BASE_HI and mem_ready=0.
REQ-007 Unselected requests SHALL be ignored, with no mem_ready and no Avalon activity.
REQ-008 In IDLE, a selected request with local_init_done=1 SHALL register the address, wdata and wstrb, then go to WR_CMD if wstrb!=0, otherwise to RD_CMD.
REQ-009 In IDLE with local_init_done=0, the block SHALL stall with no response.
REQ-010 In WR_CMD, the block SHALL drive avl_write=1 with the registered address, data and byteenable, held stable while avl_waitrequest_n=0.
REQ-011 When avl_waitrequest_n=1 is sampled in WR_CMD, the block SHALL go to RESP.
REQ-012 In RD_CMD, the block SHALL drive avl_read=1 with avl_byteenable=4'hF, held stable while avl_waitrequest_n=0.
REQ-013 When avl_waitrequest_n=1 is sampled in RD_CMD, the block SHALL go to RD_WAIT and clear the timeout counter.
REQ-014 avl_beginbursttransfer SHALL be 1 only in the first cycle of WR_CMD or RD_CMD.
REQ-015 avl_read and avl_write SHALL never both be 1.
REQ-016 In RD_WAIT, avl_readdatavalid=1 SHALL capture avl_readdata into mem_rdata and move to RESP.
REQ-017 In RD_WAIT, the 10-bit counter SHALL increment each cycle.
REQ-018 If the counter reaches RD_TIMEOUT without readdatavalid, the block SHALL load mem_rdata=32'hDEADBEEF, set err_flag, and go to ERROR via a one-cycle mem_ready pulse.
REQ-019 If readdatavalid and the timeout coincide, readdatavalid SHALL win: normal data, no error.
REQ-020 RESP SHALL assert mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-021 In the cycle after RESP, a still-high mem_valid SHALL be treated as a new request.
REQ-022 For a write, mem_rdata SHALL remain unchanged.
REQ-023 local_cal_fail=1 in any non-command state SHALL set err_flag and force ERROR.
REQ-024 In WR_CMD or RD_CMD, local_cal_fail SHALL take effect only after command acceptance, so an asserted command is never withdrawn.
REQ-025 In ERROR, every selected request SHALL receive mem_ready the next cycle with mem_rdata=32'hDEADBEEF.
REQ-026 In ERROR, writes SHALL be dropped, no Avalon command SHALL be issued, and ERROR SHALL be left only by reset.
REQ-027 Latency with zero wait states SHALL be: write, mem_ready 2 cycles after request acceptance in IDLE; read, mem_ready 1 cycle after readdatavalid.

Reset
REQ-028 On reset_reset=1, the block SHALL asynchronously enter IDLE and clear mem_ready, mem_rdata, avl_read, avl_write, avl_beginbursttransfer, avl_address, avl_writedata, avl_byteenable, err_flag, busy and the counter to 0; avl_burstcount SHALL stay 3'd1.
REQ-029 Reset asserted mid-transaction SHALL abandon it; after reset release, the block SHALL issue no response for it and ignore stray readdatavalid while in IDLE.

Verification
REQ-030 Write: init_done=1, addr 0x0000_0010, wdata 0xA5A5_1234, wstrb 4'b0011, waitrequest_n low 3 cycles -> avl_write held 4 cycles, avl_address 21'h4, byteenable 4'b0011, beginbursttransfer 1 cycle only, mem_ready 1 cycle after acceptance.
REQ-031 Read: addr 0x007F_FFFC, readdatavalid with 0xCAFE_F00D 5 cycles after acceptance -> avl_address 21'h1FFFFF, mem_rdata 0xCAFE_F00D with mem_ready 1 cycle later.
REQ-032 Timeout: RD_TIMEOUT=8, no readdatavalid -> mem_ready with 0xDEADBEEF, err_flag=1, and the next read is answered in 1 cycle with 0xDEADBEEF and no avl_read.
REQ-033 Gating: init_done=0 for 20 cycles with a pending read -> no avl_read; init_done=1 -> avl_read the cycle after next; mem_addr[31:23]!=BASE_HI -> no response.
REQ-034 Reset: assert reset_reset in RD_WAIT, release, then pulse readdatavalid -> no mem_ready, all outputs 0, state IDLE.

Source files
------------

// File: rtl/picorv32_avl_bridge.sv
// picorv32_avl_bridge
// Bridges the PicoRV32 native memory interface onto a single-beat Avalon-MM
// master port in front of a DDR3 EMIF. The 8 MB window selected by
// mem_addr[31:23] == BASE_HI is served; every other address is ignored.
//
// Ports
//   clk_clk, reset_reset        clock, asynchronous active-high reset
//   mem_valid/addr/wdata/wstrb  CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata        one-cycle completion pulse and read data
//   avl_*                       Avalon-MM master (burstcount fixed at 1)
//   local_init_done/cal_fail    EMIF calibration status
//   err_flag                    sticky error (timeout or calibration failure)
//   busy                        high in every state except IDLE and ERROR
//   dbg_state                   current FSM state, for checkers
//
// Handshakes: the CPU holds mem_valid and its payload until it sees mem_ready
// high for one cycle. On the Avalon side a command (avl_read or avl_write) is
// accepted on the rising edge where avl_waitrequest_n is 1; until then the
// command and its address/data/byteenable are held unchanged.
module picorv32_avl_bridge #(
  parameter logic [8:0] BASE_HI    = 9'h000,
  parameter int         RD_TIMEOUT = 1023
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [20:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  output logic [2:0]  avl_burstcount,
  output logic        avl_beginbursttransfer,
  input  logic        avl_waitrequest_n,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic        local_init_done,
  input  logic        local_cal_fail,
  output logic        err_flag,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    RD_CMD  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam logic [9:0]  TO_LIM   = 10'(RD_TIMEOUT);
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  state_t      state;
  logic [9:0]  to_cnt;
  logic        cal_pend;   // calibration failure seen while a command is outstanding
  logic        selected;
  logic        unused_ok;

  // mem_ready is part of the select term so the cycle carrying the response
  // never re-launches the same request.
  assign selected       = mem_valid && (mem_addr[31:23] == BASE_HI) && !mem_ready;
  assign avl_burstcount = 3'd1;
  assign dbg_state      = state;
  assign unused_ok      = &{1'b0, mem_addr[1:0]};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state                  <= IDLE;
      mem_ready              <= 1'b0;
      mem_rdata              <= 32'h0;
      avl_read               <= 1'b0;
      avl_write              <= 1'b0;
      avl_beginbursttransfer <= 1'b0;
      avl_address            <= 21'h0;
      avl_writedata          <= 32'h0;
      avl_byteenable         <= 4'h0;
      err_flag               <= 1'b0;
      busy                   <= 1'b0;
      to_cnt                 <= 10'h0;
      cal_pend               <= 1'b0;
    end else begin
      // Both are single-cycle pulses unless a branch below re-asserts them.
      mem_ready              <= 1'b0;
      avl_beginbursttransfer <= 1'b0;

      case (state)
        IDLE: begin
          if (local_cal_fail) begin
            err_flag <= 1'b1;
            state    <= ERROR;
          end else if (selected && local_init_done) begin
            avl_address            <= mem_addr[22:2];
            avl_writedata          <= mem_wdata;
            avl_beginbursttransfer <= 1'b1;
            busy                   <= 1'b1;
            if (mem_wstrb != 4'h0) begin
              avl_byteenable <= mem_wstrb;
              avl_write      <= 1'b1;
              state          <= WR_CMD;
            end else begin
              avl_byteenable <= 4'hF;
              avl_read       <= 1'b1;
              state          <= RD_CMD;
            end
          end
        end

        WR_CMD, RD_CMD: begin
          // A calibration failure is remembered but the command stays on the
          // bus until the slave accepts it.
          if (local_cal_fail) cal_pend <= 1'b1;
          if (avl_waitrequest_n) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            cal_pend  <= 1'b0;
            if (local_cal_fail || cal_pend) begin
              err_flag <= 1'b1;
              busy     <= 1'b0;
              state    <= ERROR;
            end else if (state == WR_CMD) begin
              mem_ready <= 1'b1;
              state     <= RESP;
            end else begin
              to_cnt <= 10'h0;
              state  <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          to_cnt <= to_cnt + 10'd1;
          if (local_cal_fail) begin
            err_flag <= 1'b1;
            busy     <= 1'b0;
            state    <= ERROR;
          end else if (avl_readdatavalid) begin
            // Data arriving in the final allowed cycle beats the timeout.
            mem_rdata <= avl_readdata;
            mem_ready <= 1'b1;
            state     <= RESP;
          end else if (to_cnt + 10'd1 == TO_LIM) begin
            mem_rdata <= ERR_WORD;
            mem_ready <= 1'b1;
            err_flag  <= 1'b1;
            busy      <= 1'b0;
            state     <= ERROR;
          end
        end

        RESP: begin
          busy <= 1'b0;
          if (local_cal_fail) begin
            err_flag <= 1'b1;
            state    <= ERROR;
          end else begin
            state <= IDLE;
          end
        end

        ERROR: begin
          // Terminal until reset: answer every selected request with the
          // error word, never touch the Avalon bus.
          if (selected) begin
            mem_ready <= 1'b1;
            mem_rdata <= ERR_WORD;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
